seven_seg_readback: RTL

//  Receive side of the seven-segment display interface: watches an active-low
//  {sign, seg[6:0]} display bus and recovers the signed digit being shown.

---
 rtl/seven_seg_readback.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_readback.sv
// Recovers the signed digit shown on an active-low {sign, seg} display bus and presents it on valid/ready.
// Optional feature: define SEVEN_SEG_READBACK_BLANK_EN to report blank patterns as transactions.
module seven_seg_readback #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       sign,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [4:0] out_value,
  output logic       out_err,
  output logic       out_blank,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [7:0]    sync_q [SYNC_STAGES];
  logic [7:0]    synced, smp_nxt;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q;
  logic          last_vld_q;
  logic [4:0]    val_q, val_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          same, accept, reportable, load;
  logic [3:0]    mag;
  logic          legal, is_blank;
  logic [4:0]    dec_val;
  logic          dec_err;

`ifdef SEVEN_SEG_READBACK_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
  logic blank_q, blank_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= 1'b0;
    else     blank_q <= blank_d;
  end
  assign out_blank = blank_q;
`else
  localparam bit BLANK_EN = 1'b0;
  assign out_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h7F;
    end else begin
      sync_q[0] <= {sign, seg};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Comparing the sample about to enter the last stage lets the count update on
  // the same edge as the synced value, giving SYNC_STAGES+STABLE_CYCLES latency.
  generate
    if (SYNC_STAGES == 1) begin : g_nxt_raw
      assign smp_nxt = {sign, seg};
    end else begin : g_nxt_chain
      assign smp_nxt = sync_q[SYNC_STAGES-2];
    end
  endgenerate

  assign same   = (smp_nxt == synced);
  assign accept = same && (count_q == CW'(STABLE_CYCLES - 1)) &&
                  (!last_vld_q || (synced != last_q));

  always_comb begin
    if (!same)                              count_d = '0;
    else if (count_q == CW'(STABLE_CYCLES)) count_d = count_q;
    else                                    count_d = count_q + 1'b1;
  end

  always_comb begin
    mag   = '0;
    legal = 1'b1;
    case (synced[6:0])
      7'b1000000: mag = 4'd0;
      7'b1111001: mag = 4'd1;
      7'b0100100: mag = 4'd2;
      7'b0110000: mag = 4'd3;
      7'b0011001: mag = 4'd4;
      7'b0010010: mag = 4'd5;
      7'b0000010: mag = 4'd6;
      7'b1111000: mag = 4'd7;
      7'b0000000: mag = 4'd8;
      7'b0010000: mag = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

  assign is_blank   = (synced[6:0] == 7'h7F);
  assign dec_err    = !legal && !is_blank;
  assign dec_val    = !legal ? 5'd0 : (synced[7] ? (~{1'b0, mag} + 5'd1) : {1'b0, mag});
  assign reportable = accept && (!is_blank || BLANK_EN);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    err_d   = err_q;
    load    = 1'b0;
    ovf_d   = ovf_q && !clr_ovf;
`ifdef SEVEN_SEG_READBACK_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (reportable) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (reportable) load    = 1'b1;
          else            state_d = IDLE;
        end else if (reportable) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      val_d = dec_val;
      err_d = dec_err;
`ifdef SEVEN_SEG_READBACK_BLANK_EN
      blank_d = is_blank;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      val_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val_q   <= val_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        last_q     <= synced;
        last_vld_q <= 1'b1;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_value = val_q;
  assign out_err   = err_q;
  assign overrun   = ovf_q;

endmodule
